pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage pipeline.
- Drives EN of the PC and the IF/ID instruction register, plus NOP-insert (flush) strobes for IF/ID and ID/EX.
- Resolves load-use hazards with a programmable stall length, flushes wrong-path instructions on taken branches, and bubbles decode while instruction memory is not ready.
- Keeps saturating stall/flush performance counters and a sticky fetch-timeout flag.

Parameters:
- LU_CYCLES, 1, stall cycles per load-use hazard (1..7).
- TIMEOUT, 64, consecutive IMEM-not-ready cycles before FETCH_ERR sets (>=2).
- CNT_W, 16, width of performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- ID_RS  in  5  rs of instruction in ID (IF/ID register output).
- ID_RT  in  5  rt of instruction in ID.
- ID_USES_RT  in  1  ID instruction reads rt.
- EX_RT  in  5  destination rt of instruction in EX.
- EX_MEMREAD  in  1  instruction in EX is a load.
- EX_BR_TAKEN  in  1  branch/jump resolved taken in EX.
- IMEM_READY  in  1  fetch data valid this cycle.
- PC_EN  out  1  PC load enable.
- IR_EN  out  1  IF/ID register enable.
- IR_FLUSH  out  1  IF/ID loads NOP at next edge (requires IR_EN=1).
- IDEX_FLUSH  out  1  ID/EX loads NOP at next edge.
- STALL_CNT  out  CNT_W  saturating count of cycles with PC_EN=0, excluding reset.
- FLUSH_CNT  out  CNT_W  saturating count of taken-branch flushes.
- FETCH_ERR  out  1  sticky IMEM timeout.

Behaviour:
- Outputs PC_EN, IR_EN, IR_FLUSH and IDEX_FLUSH are combinational (Mealy) from state and inputs. STALL_CNT, FLUSH_CNT and FETCH_ERR are registered.
- Reset (RST_N=0 at an edge):
  - State becomes RUN; lu_cnt, wait_cnt, STALL_CNT, FLUSH_CNT and FETCH_ERR clear to 0.
  - While RST_N=0, outputs are forced to PC_EN=0, IR_EN=1, IR_FLUSH=1, IDEX_FLUSH=1.
  - Reset mid-stall or mid-wait aborts the stall/wait with no residue.
- Hazard definitions:
  - LU = EX_MEMREAD & (EX_RT!=0) & ((EX_RT==ID_RS) | (ID_USES_RT & EX_RT==ID_RT)).
  - BR = EX_BR_TAKEN.
- Priority in every state: BR > LU > IMEM_READY=0.
- Output sets:
  - BR: PC_EN=1, IR_EN=1, IR_FLUSH=1, IDEX_FLUSH=1; FLUSH_CNT+1; next state RUN; lu_cnt and wait_cnt clear.
  - LU: PC_EN=0, IR_EN=0, IR_FLUSH=0, IDEX_FLUSH=1. If LU_CYCLES>1, next state LU_STALL with lu_cnt=LU_CYCLES-1; otherwise next state RUN.
  - WAIT (IMEM_READY=0): PC_EN=0, IR_EN=1, IR_FLUSH=1, IDEX_FLUSH=0. The ID instruction advances and decode receives a bubble. Next state IMEM_WAIT; wait_cnt increments, saturating at TIMEOUT.
  - NORMAL: PC_EN=1, IR_EN=1, both flushes 0.
- States:
  - RUN: apply the highest-priority applicable set; NORMAL if none applies.
  - LU_STALL: LU output set unconditionally unless BR. lu_cnt decrements each cycle; when lu_cnt==1, next state RUN.
  - IMEM_WAIT: BR, then LU (goes to LU_STALL or RUN per LU_CYCLES, wait_cnt clears), then WAIT while IMEM_READY=0. On IMEM_READY=1: NORMAL set, next state RUN, wait_cnt clears.
- Timeout: when wait_cnt reaches TIMEOUT-1 and IMEM_READY is still 0, FETCH_ERR=1 from the next cycle until reset. The block keeps waiting.
- Counters:
  - STALL_CNT increments every non-reset cycle with PC_EN=0.
  - Both counters stick at 2^CNT_W-1.
- Simultaneous BR and LU: BR wins. The load-dependent ID instruction is flushed, so no stall is taken.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encodings RUN=2'd0, LU_STALL=2'd1, IMEM_WAIT=2'd2;
  - a register-zero constant (5'd0).
- Sub-module sat_counter (parameter W; inputs CLK, RST_N, INC; output Q), instantiated twice for STALL_CNT and FLUSH_CNT.
- LU comparison stays inline.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with EX_BR_TAKEN=1 -> PC_EN=0, IR_FLUSH=1, IDEX_FLUSH=1; after release, all counters 0, FETCH_ERR=0, state RUN.
- Load-use, LU_CYCLES=2: EX_MEMREAD=1, EX_RT=5, ID_RS=5 for one cycle, then EX_MEMREAD=0 -> PC_EN=0 and IDEX_FLUSH=1 for exactly 2 cycles, then NORMAL; STALL_CNT=2. Repeat with EX_RT=0 -> no stall.
- Rt-use gating: EX_RT=7, ID_RT=7, ID_USES_RT=0 -> NORMAL; with ID_USES_RT=1 -> stall.
- Branch vs load-use same cycle: EX_BR_TAKEN=1 with an LU match -> PC_EN=1, IR_FLUSH=1, IDEX_FLUSH=1, no stall; FLUSH_CNT=1, STALL_CNT=0.
- IMEM wait, TIMEOUT=4: IMEM_READY=0 for 5 cycles -> PC_EN=0, IR_FLUSH=1 each cycle; FETCH_ERR rises after the 4th cycle; IMEM_READY=1 -> NORMAL; FETCH_ERR stays 1 until RST_N=0.
- Saturation, CNT_W=3: 9 taken branches -> FLUSH_CNT=7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        IMEM_WAIT = 2'd2
    } state_t;

    // Architectural register zero is never a real data dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One bundle for the four pipeline control strobes.
    typedef struct packed {
        logic pc_en;
        logic ir_en;
        logic ir_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = 4'b1100;
    localparam ctrl_t CTRL_BR     = 4'b1111;
    localparam ctrl_t CTRL_LU     = 4'b0001;
    localparam ctrl_t CTRL_WAIT   = 4'b0110;
    localparam ctrl_t CTRL_RST    = 4'b0111;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         INC,
    output logic [W-1:0] Q
);

    // Count up on INC, hold once all ones is reached.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RST_N) begin
            Q <= '0;
        end else if (INC && (Q != {W{1'b1}})) begin
            Q <= Q + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use stalls, taken-branch
// flushes, instruction-memory wait bubbles, perf counters and fetch timeout.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_CYCLES = 1,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_USES_RT,
    input  logic [4:0]       EX_RT,
    input  logic             EX_MEMREAD,
    input  logic             EX_BR_TAKEN,
    input  logic             IMEM_READY,
    output logic             PC_EN,
    output logic             IR_EN,
    output logic             IR_FLUSH,
    output logic             IDEX_FLUSH,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT,
    output logic             FETCH_ERR
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [2:0]        LU_RELOAD = 3'(LU_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [2:0]        lu_cnt, lu_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              lu_hit;
    logic              flush_inc;
    logic              err_set;
    ctrl_t             ctrl;

    // Load in EX writes a register the ID instruction reads.
    assign lu_hit = EX_MEMREAD && (EX_RT != REG_ZERO) &&
                    ((EX_RT == ID_RS) || (ID_USES_RT && (EX_RT == ID_RT)));

    // Next state and Mealy strobes; priority is branch, then load-use, then fetch wait.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        lu_cnt_nxt   = lu_cnt;
        wait_cnt_nxt = '0;
        ctrl         = CTRL_NORMAL;
        flush_inc    = 1'b0;
        err_set      = 1'b0;

        if (!RST_N) begin
            ctrl = CTRL_RST;
        end else if (EX_BR_TAKEN) begin
            // Wrong-path instructions in IF and ID are squashed; any pending stall is moot.
            ctrl       = CTRL_BR;
            flush_inc  = 1'b1;
            state_nxt  = RUN;
            lu_cnt_nxt = '0;
        end else begin
            case (state)
                LU_STALL: begin
                    ctrl       = CTRL_LU;
                    lu_cnt_nxt = lu_cnt - 3'd1;
                    if (lu_cnt <= 3'd1) begin
                        state_nxt  = RUN;
                        lu_cnt_nxt = '0;
                    end
                end
                default: begin
                    // RUN and IMEM_WAIT share the same decision order; the wait counter
                    // only survives while the wait set keeps being selected.
                    if (lu_hit) begin
                        ctrl = CTRL_LU;
                        if (LU_CYCLES > 1) begin
                            state_nxt  = LU_STALL;
                            lu_cnt_nxt = LU_RELOAD;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else if (!IMEM_READY) begin
                        ctrl         = CTRL_WAIT;
                        state_nxt    = IMEM_WAIT;
                        wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);
                        err_set      = (wait_cnt >= WAIT_LAST);
                    end else begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    // State, stall/wait counters and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= RUN;
            lu_cnt    <= '0;
            wait_cnt  <= '0;
            FETCH_ERR <= 1'b0;
        end else begin
            state    <= state_nxt;
            lu_cnt   <= lu_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set) begin
                FETCH_ERR <= 1'b1;
            end
        end
    end

    assign PC_EN      = ctrl.pc_en;
    assign IR_EN      = ctrl.ir_en;
    assign IR_FLUSH   = ctrl.ir_flush;
    assign IDEX_FLUSH = ctrl.idex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (!ctrl.pc_en),
        .Q     (STALL_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (flush_inc),
        .Q     (FLUSH_CNT)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: decode vector table, directed
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_pipe_hazard_ctrl;

    localparam int LU_CYCLES = 2;
    localparam int TIMEOUT   = 4;
    localparam int CNT_W     = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    // {PC_EN, IR_EN, IR_FLUSH, IDEX_FLUSH}
    localparam logic [3:0] O_NORMAL = 4'b1100;
    localparam logic [3:0] O_BR     = 4'b1111;
    localparam logic [3:0] O_LU     = 4'b0001;
    localparam logic [3:0] O_WAIT   = 4'b0110;
    localparam logic [3:0] O_RST    = 4'b0111;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [4:0]       ID_RS, ID_RT, EX_RT;
    logic             ID_USES_RT, EX_MEMREAD, EX_BR_TAKEN, IMEM_READY;
    logic             PC_EN, IR_EN, IR_FLUSH, IDEX_FLUSH;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;
    logic             FETCH_ERR;
    logic [3:0]       outs;

    int total = 0;
    int bad   = 0;

    assign outs = {PC_EN, IR_EN, IR_FLUSH, IDEX_FLUSH};

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(
        .LU_CYCLES (LU_CYCLES),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ID_RS       (ID_RS),
        .ID_RT       (ID_RT),
        .ID_USES_RT  (ID_USES_RT),
        .EX_RT       (EX_RT),
        .EX_MEMREAD  (EX_MEMREAD),
        .EX_BR_TAKEN (EX_BR_TAKEN),
        .IMEM_READY  (IMEM_READY),
        .PC_EN       (PC_EN),
        .IR_EN       (IR_EN),
        .IR_FLUSH    (IR_FLUSH),
        .IDEX_FLUSH  (IDEX_FLUSH),
        .STALL_CNT   (STALL_CNT),
        .FLUSH_CNT   (FLUSH_CNT),
        .FETCH_ERR   (FETCH_ERR)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] exrt;
        logic       uses;
        logic       mr;
        logic       br;
        logic       rdy;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] exrt, input logic mr, input logic br, input logic rdy);
        ID_RS       = rs;
        ID_RT       = rt;
        ID_USES_RT  = uses;
        EX_RT       = exrt;
        EX_MEMREAD  = mr;
        EX_BR_TAKEN = br;
        IMEM_READY  = rdy;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    endtask

    // Inputs change on the falling edge, comparisons land 1ns later.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        idle();
        cyc();
        RST_N = 1'b1;
    endtask

    // Reference model: remaining forced stall cycles, length of the current
    // not-ready run, and plain integer counters.
    int   m_stall_left, m_wait_run, m_stalls, m_flushes;
    bit   m_err;
    logic [3:0] m_exp;
    bit   m_lu;
    bit   rdy_mode;

    initial begin
        // Reset holds outputs regardless of a taken branch.
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
        RST_N = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("reset_outs%0d", k), outs, O_RST);
            cyc();
        end
        RST_N = 1'b1;
        idle();
        #1;
        check("reset_stall_cnt", STALL_CNT, 0);
        check("reset_flush_cnt", FLUSH_CNT, 0);
        check("reset_fetch_err", FETCH_ERR, 0);
        check("reset_run_normal", outs, O_NORMAL);

        // Single-cycle decode from RUN.
        vecs[0]  = '{5'd1,  5'd2, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, O_NORMAL};
        vecs[1]  = '{5'd5,  5'd2, 5'd5,  1'b0, 1'b1, 1'b0, 1'b1, O_LU};
        vecs[2]  = '{5'd1,  5'd7, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, O_LU};
        vecs[3]  = '{5'd1,  5'd7, 5'd7,  1'b0, 1'b1, 1'b0, 1'b1, O_NORMAL};
        vecs[4]  = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, O_NORMAL};
        vecs[5]  = '{5'd5,  5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, O_NORMAL};
        vecs[6]  = '{5'd5,  5'd2, 5'd5,  1'b0, 1'b1, 1'b1, 1'b1, O_BR};
        vecs[7]  = '{5'd1,  5'd2, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_WAIT};
        vecs[8]  = '{5'd5,  5'd2, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, O_LU};
        vecs[9]  = '{5'd1,  5'd2, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, O_BR};
        vecs[10] = '{5'd31, 5'd2, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, O_LU};
        for (int i = 0; i < 11; i++) begin
            do_reset();
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].exrt,
                  vecs[i].mr, vecs[i].br, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d", i), outs, vecs[i].exp);
        end

        // Load-use stalls exactly LU_CYCLES cycles.
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        #1; check("lu_cycle1", outs, O_LU);
        cyc();
        idle();
        #1; check("lu_cycle2", outs, O_LU);
        cyc();
        #1; check("lu_done", outs, O_NORMAL);
        check("lu_stall_cnt", STALL_CNT, 2);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        #1; check("lu_r0_a", outs, O_NORMAL);
        cyc();
        #1; check("lu_r0_b", outs, O_NORMAL);
        check("lu_r0_stall_cnt", STALL_CNT, 2);

        // Branch overrides a load-use in the same cycle.
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
        #1; check("br_lu_outs", outs, O_BR);
        cyc();
        idle();
        #1; check("br_lu_after", outs, O_NORMAL);
        check("br_lu_flush_cnt", FLUSH_CNT, 1);
        check("br_lu_stall_cnt", STALL_CNT, 0);

        // Branch cuts a multi-cycle stall short.
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        #1; check("br_in_stall", outs, O_BR);
        cyc();
        idle();
        #1; check("br_in_stall_after", outs, O_NORMAL);

        // Reset in the middle of a stall leaves nothing behind.
        do_reset();
        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        cyc();
        do_reset();
        #1; check("midstall_reset_outs", outs, O_NORMAL);
        check("midstall_reset_cnt", STALL_CNT, 0);

        // Fetch timeout: flag appears after the TIMEOUT-th not-ready cycle.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("wait_outs%0d", k), outs, O_WAIT);
            check($sformatf("wait_err%0d", k), FETCH_ERR, (k > TIMEOUT) ? 1 : 0);
            cyc();
        end
        idle();
        #1; check("wait_release", outs, O_NORMAL);
        check("wait_err_sticky", FETCH_ERR, 1);
        check("wait_stall_cnt", STALL_CNT, 5);
        cyc();
        #1; check("wait_err_sticky2", FETCH_ERR, 1);
        do_reset();
        #1; check("wait_err_cleared", FETCH_ERR, 0);

        // Flush counter saturation.
        do_reset();
        drive(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) cyc();
        idle();
        #1; check("sat_flush_cnt", FLUSH_CNT, CNT_MAX);
        check("sat_stall_cnt", STALL_CNT, 0);

        // Randomized traffic against the reference model.
        do_reset();
        m_stall_left = 0; m_wait_run = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
        rdy_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            RST_N       = ($urandom_range(0, 99) != 0);
            ID_RS       = 5'($urandom_range(0, 3));
            ID_RT       = 5'($urandom_range(0, 3));
            EX_RT       = 5'($urandom_range(0, 3));
            ID_USES_RT  = 1'($urandom_range(0, 1));
            EX_MEMREAD  = 1'($urandom_range(0, 1));
            EX_BR_TAKEN = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) rdy_mode = ~rdy_mode;
            IMEM_READY  = rdy_mode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            #1;
            check($sformatf("rnd_cnt%0d", n), {STALL_CNT, FLUSH_CNT, FETCH_ERR},
                  {CNT_W'(m_stalls), CNT_W'(m_flushes), m_err});
            m_lu = EX_MEMREAD && (EX_RT != 0) &&
                   ((EX_RT == ID_RS) || (ID_USES_RT && (EX_RT == ID_RT)));
            if (!RST_N) begin
                m_exp = O_RST;
                m_stall_left = 0; m_wait_run = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
            end else begin
                if (EX_BR_TAKEN) begin
                    m_exp = O_BR;
                    m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
                    m_stall_left = 0;
                    m_wait_run = 0;
                end else if (m_stall_left > 0) begin
                    m_exp = O_LU;
                    m_stall_left--;
                    m_wait_run = 0;
                end else if (m_lu) begin
                    m_exp = O_LU;
                    m_stall_left = LU_CYCLES - 1;
                    m_wait_run = 0;
                end else if (!IMEM_READY) begin
                    m_exp = O_WAIT;
                    if (m_wait_run >= TIMEOUT - 1) m_err = 1;
                    m_wait_run = (m_wait_run < TIMEOUT) ? m_wait_run + 1 : TIMEOUT;
                end else begin
                    m_exp = O_NORMAL;
                    m_wait_run = 0;
                end
                if (m_exp[3] == 1'b0) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
            end
            check($sformatf("rnd_outs%0d", n), outs, m_exp);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
